// File: rtl/lbm_pkg.sv
// Shared LBM types for the distribution-function store: D2Q9 velocity indices,
// the packed node vector, the FSM state encoding and a lane slice helper.
package lbm_pkg;

    localparam int LBM_Q          = 9;
    localparam int LBM_DATA_WIDTH = 32;

    // D2Q9 order: rest, four axis directions (+x,+y,-x,-y), four diagonals.
    typedef enum logic [3:0] {
        E0 = 4'd0, E1 = 4'd1, E2 = 4'd2, E3 = 4'd3, E4 = 4'd4,
        E5 = 4'd5, E6 = 4'd6, E7 = 4'd7, E8 = 4'd8
    } velocity_e;

    typedef logic signed [LBM_Q*LBM_DATA_WIDTH-1:0] dist_vec_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_e;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/distribution_lane_ram.sv
// One velocity lane of one bank: simple dual-port RAM with registered read,
// shaped so synthesis maps it onto a block RAM.
module distribution_lane_ram #(
    parameter int DEPTH         = 256,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     Clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage write port and registered read port; no reset so it stays a BRAM.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/distribution_pingpong_ram.sv
// Ping-pong D2Q9 distribution store: reads from cur_bank, masked writes into the
// other bank, single-cycle swap, and an init sequencer that fills both banks.
module distribution_pingpong_ram
    import lbm_pkg::*;
#(
    parameter int DEPTH         = 256,
    parameter int Q             = LBM_Q,
    parameter int DATA_WIDTH    = LBM_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                init_req,
    input  logic signed [Q*DATA_WIDTH-1:0]      init_data,
    output logic                                busy,
    output logic                                cur_bank,
    input  logic                                rd_en,
    input  logic [ADDRESS_WIDTH-1:0]            rd_addr,
    output logic signed [Q*DATA_WIDTH-1:0]      rd_data,
    output logic                                rd_valid,
    input  logic                                wr_en,
    input  logic [ADDRESS_WIDTH-1:0]            wr_addr,
    input  logic [Q-1:0]                        wr_mask,
    input  logic signed [Q*DATA_WIDTH-1:0]      wr_data,
    input  logic                                swap
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_X   = (ADDRESS_WIDTH + 1)'(DEPTH);

    ram_state_e                 state_r;
    logic [ADDRESS_WIDTH-1:0]   cnt_r;
    logic                       rd_pend_r;
    logic                       rd_bank_r;

    logic                       init_wr_s;
    logic                       run_s;
    logic                       rd_acc_s;
    logic                       wr_acc_s;
    logic                       next_bank_s;
    logic [ADDRESS_WIDTH-1:0]   ram_waddr_s;
    logic [Q*DATA_WIDTH-1:0]    ram_wdata_s;
    logic [Q*DATA_WIDTH-1:0]    rd_mux_s;
    logic [DATA_WIDTH-1:0]      lane_q_s [2][Q];

    // init_req in RUN wins over every other request issued in the same cycle.
    assign init_wr_s   = (state_r == INIT) && !Reset;
    assign run_s       = (state_r == RUN) && !Reset && !init_req;
    assign rd_acc_s    = run_s && rd_en;
    assign wr_acc_s    = run_s && wr_en && ({1'b0, wr_addr} < DEPTH_X);
    assign next_bank_s = ~cur_bank;
    assign ram_waddr_s = init_wr_s ? cnt_r : wr_addr;
    assign ram_wdata_s = init_wr_s ? init_data : wr_data;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar k = 0; k < Q; k++) begin : g_lane
            logic lane_we_s;

            assign lane_we_s = init_wr_s ||
                               (wr_acc_s && wr_mask[k] && (next_bank_s == 1'(b)));

            distribution_lane_ram #(
                .DEPTH         (DEPTH),
                .DATA_WIDTH    (DATA_WIDTH),
                .ADDRESS_WIDTH (ADDRESS_WIDTH)
            ) u_lane (
                .Clk   (Clk),
                .we    (lane_we_s),
                .waddr (ram_waddr_s),
                .wdata (ram_wdata_s[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
                .re    (rd_acc_s),
                .raddr (rd_addr),
                .rdata (lane_q_s[b][k])
            );
        end
    end

    // Select the bank that was current when the read was accepted.
    always_comb begin
        rd_mux_s = {(Q*DATA_WIDTH){1'b0}};
        for (int k = 0; k < Q; k++) begin
            rd_mux_s[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
                rd_bank_r ? lane_q_s[1][k] : lane_q_s[0][k];
        end
    end

    // Control FSM, bank role, read pipeline and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= INIT;
            cnt_r     <= {ADDRESS_WIDTH{1'b0}};
            busy      <= 1'b1;
            cur_bank  <= 1'b0;
            rd_pend_r <= 1'b0;
            rd_bank_r <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= {(Q*DATA_WIDTH){1'b0}};
        end else begin
            case (state_r)
                INIT: begin
                    if (cnt_r == LAST_ADDR) begin
                        state_r <= RUN;
                        busy    <= 1'b0;
                        cnt_r   <= {ADDRESS_WIDTH{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r + ADDRESS_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (init_req) begin
                        state_r <= INIT;
                        busy    <= 1'b1;
                        cnt_r   <= {ADDRESS_WIDTH{1'b0}};
                    end else if (swap) begin
                        cur_bank <= ~cur_bank;
                    end
                end
                default: begin
                    state_r <= INIT;
                    busy    <= 1'b1;
                    cnt_r   <= {ADDRESS_WIDTH{1'b0}};
                end
            endcase

            rd_pend_r <= rd_acc_s;
            rd_bank_r <= cur_bank;
            rd_valid  <= rd_pend_r;
            if (rd_pend_r) begin
                rd_data <= rd_mux_s;
            end
        end
    end

endmodule
